// File: rtl/hazard_pkg.sv
// Shared encodings and tag-entry layout for the decode hazard/forwarding unit.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_IDEX  = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;
    localparam logic [1:0] FWD_MEMWB = 2'd3;

    localparam int CTRL_CALL = 0;
    localparam int CTRL_RET  = 1;
    localparam int CTRL_BR   = 2;

    localparam int TAG_AW = 8;

    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic [TAG_AW-1:0] addr;
    } tag_t;

    // A fourth tracked stage has no encoding of its own; it reads as MEMWB.
    function automatic logic [1:0] fwd_code(input int s);
        return (s >= 3) ? FWD_MEMWB : 2'(s + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_if.sv
// Decode-side hazard bundle: master drives decode/control, slave answers.
interface hazard_unit_fwd_if #(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 16
);
    logic                     dec_valid;
    logic                     dec_wr_en;
    logic [ADDR_W-1:0]        dec_wr_addr;
    logic                     dec_is_load;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [2:0]               ctrl_issue;
    logic [2:0]               ctrl_clr;
    logic                     flush;
    logic                     data_hazard;
    logic [NUM_RD*2-1:0]      fwd_sel;
    logic                     control_hazard;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output dec_valid, dec_wr_en, dec_wr_addr, dec_is_load,
        output rd_en, rd_addr, ctrl_issue, ctrl_clr, flush,
        input  data_hazard, fwd_sel, control_hazard, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_wr_en, dec_wr_addr, dec_is_load,
        input  rd_en, rd_addr, ctrl_issue, ctrl_clr, flush,
        output data_hazard, fwd_sel, control_hazard, stall_cnt
    );
endinterface

// File: rtl/hazard_tag_pipe.sv
// Destination-tag shift register mirroring IDEX/EXMEM/MEMWB occupancy.
module hazard_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             bubble_i,
    input  tag_t             in_i,
    output tag_t [DEPTH-1:0] tag_o
);
    tag_t [DEPTH-1:0] tag_q;
    tag_t [DEPTH-1:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = bubble_i ? '0 : in_i;
        for (int s = 1; s < DEPTH; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        if (flush_i) begin
            tag_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/hazard_unit_fwd.sv
// Decode hazard detection with per-port operand forwarding select,
// control-redirect tracking and a saturating stall counter.
module hazard_unit_fwd
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    hazard_unit_fwd_if.slave hz
);
    tag_t [DEPTH-1:0]  tag;
    tag_t              new_tag;
    logic [NUM_RD-1:0] stall_p;
    logic              stall;
    logic [2:0]        pend_q;
    logic [2:0]        pend_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        new_tag         = '0;
        new_tag.valid   = hz.dec_valid & hz.dec_wr_en;
        new_tag.is_load = hz.dec_is_load;
        new_tag.addr    = TAG_AW'(hz.dec_wr_addr);
    end

    hazard_tag_pipe #(.DEPTH(DEPTH)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (hz.flush),
        .bubble_i (stall),
        .in_i     (new_tag),
        .tag_o    (tag)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] ra;
        logic [DEPTH-1:0]  hit;
        logic [1:0]        sel;
        logic              st;

        assign ra = hz.rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            hit = '0;
            for (int s = 0; s < DEPTH; s++) begin
                hit[s] = hz.rd_en[p] & tag[s].valid
                       & (tag[s].addr == TAG_AW'(ra));
            end
        end

        // Walk oldest to youngest so the youngest match wins.
        always_comb begin
            sel = FWD_RF;
            st  = 1'b0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (hit[s]) begin
                    sel = fwd_code(s);
                    st  = tag[s].is_load & (s == 0);
                end
            end
            if (FWD_EN == 0) begin
                sel = FWD_RF;
                st  = |hit;
            end
        end

        assign hz.fwd_sel[p*2 +: 2] = sel;
        assign stall_p[p]           = st;
    end

    assign stall          = |stall_p;
    assign hz.data_hazard = stall;

    always_comb begin
        pend_d = pend_q & ~hz.ctrl_clr;
        if (!stall) begin
            pend_d = pend_d | hz.ctrl_issue;
        end
        if (hz.flush) begin
            pend_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hz.control_hazard = pend_q[CTRL_CALL] | pend_q[CTRL_RET]
                             | pend_q[CTRL_BR];
    assign hz.stall_cnt      = cnt_q;

endmodule

// File: tb/tb_hazard_unit_fwd.sv
// Directed scoreboard bench for hazard_unit_fwd (forwarding and legacy builds).
module tb_hazard_unit_fwd;

    typedef struct {
        logic        dh;
        logic [3:0]  fwd;
        logic        ch;
        logic [15:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid, dec_wr_en, dec_is_load, flush;
    logic [4:0] dec_wr_addr;
    logic [1:0] rd_en;
    logic [9:0] rd_addr;
    logic [2:0] ctrl_issue, ctrl_clr;

    int   checks = 0;
    int   fails  = 0;
    exp_t sbq[$];
    exp_t e;
    logic [21:0] got, want;

    always #5 clk = ~clk;

    hazard_unit_fwd_if #(.ADDR_W(5), .NUM_RD(2), .CNT_W(16)) if_f ();
    hazard_unit_fwd_if #(.ADDR_W(5), .NUM_RD(2), .CNT_W(4))  if_l ();

    hazard_unit_fwd #(.FWD_EN(1), .CNT_W(16)) u_f (
        .clk(clk), .rst(rst), .hz(if_f)
    );
    hazard_unit_fwd #(.FWD_EN(0), .CNT_W(4)) u_l (
        .clk(clk), .rst(rst), .hz(if_l)
    );

    assign if_f.dec_valid   = dec_valid;
    assign if_f.dec_wr_en   = dec_wr_en;
    assign if_f.dec_wr_addr = dec_wr_addr;
    assign if_f.dec_is_load = dec_is_load;
    assign if_f.rd_en       = rd_en;
    assign if_f.rd_addr     = rd_addr;
    assign if_f.ctrl_issue  = ctrl_issue;
    assign if_f.ctrl_clr    = ctrl_clr;
    assign if_f.flush       = flush;
    assign if_l.dec_valid   = dec_valid;
    assign if_l.dec_wr_en   = dec_wr_en;
    assign if_l.dec_wr_addr = dec_wr_addr;
    assign if_l.dec_is_load = dec_is_load;
    assign if_l.rd_en       = rd_en;
    assign if_l.rd_addr     = rd_addr;
    assign if_l.ctrl_issue  = ctrl_issue;
    assign if_l.ctrl_clr    = ctrl_clr;
    assign if_l.flush       = flush;

    task automatic drive(input int v, we, wa, ld, re, r0, r1, iss, clr, fl);
        dec_valid   = 1'(v);
        dec_wr_en   = 1'(we);
        dec_wr_addr = 5'(wa);
        dec_is_load = 1'(ld);
        rd_en       = 2'(re);
        rd_addr     = {5'(r1), 5'(r0)};
        ctrl_issue  = 3'(iss);
        ctrl_clr    = 3'(clr);
        flush       = 1'(fl);
    endtask

    task automatic expect_(input int dh, fw, ch, cn);
        exp_t x;
        x.dh  = 1'(dh);
        x.fwd = 4'(fw);
        x.ch  = 1'(ch);
        x.cnt = 16'(cn);
        sbq.push_back(x);
    endtask

    function automatic logic [21:0] got_f();
        return {if_f.data_hazard, if_f.fwd_sel, if_f.control_hazard,
                if_f.stall_cnt};
    endfunction

    function automatic logic [21:0] got_l();
        return {if_l.data_hazard, if_l.fwd_sel, if_l.control_hazard,
                12'd0, if_l.stall_cnt};
    endfunction

    task automatic do_rst();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 3, 0, 9, 0, 0, 0);
            expect_(0, 0, 0, 0);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            checks++;
            if (got_f() !== want) begin
                fails++;
                $display("FAIL reset_f[%0d] got %h want %h", i, got_f(), want);
            end
            checks++;
            if (got_l() !== want) begin
                fails++;
                $display("FAIL reset_l[%0d] got %h want %h", i, got_l(), want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_fwd();
        do_rst();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
            else        drive(1, 0, 0, 0, 1, 5, 0, 0, 0, 0);
            expect_(0, i, 0, 0);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_f();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL alu_fwd[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_multi_port();
        int fx [5] = '{0, 0, 'h9, 'hD, 0};
        do_rst();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
                1: drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
                2: drive(1, 1, 2, 0, 3, 2, 1, 0, 0, 0);
                3: drive(1, 0, 0, 0, 3, 2, 1, 0, 0, 0);
                default: drive(1, 0, 0, 0, 3, 9, 1, 0, 0, 0);
            endcase
            expect_(0, fx[i], 0, 0);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_f();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL multi_port[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        int dx [4] = '{0, 1, 0, 0};
        int fx [4] = '{0, 'h4, 'h8, 'hC};
        int cx [4] = '{0, 0, 1, 1};
        do_rst();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
            else        drive(1, 0, 0, 0, 2, 0, 7, 0, 0, 0);
            expect_(dx[i], fx[i], 0, cx[i]);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_f();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL load_use[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_legacy();
        int dx [5] = '{0, 1, 1, 1, 0};
        int cx [5] = '{0, 0, 1, 2, 3};
        do_rst();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
            else        drive(1, 0, 0, 0, 1, 3, 0, 0, 0, 0);
            expect_(dx[i], 0, 0, cx[i]);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_l();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL legacy[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ctrl();
        int hx [7] = '{0, 1, 1, 1, 1, 1, 0};
        do_rst();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
                3: drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
                5: drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            expect_(0, 0, hx[i], 0);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_f();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL ctrl[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        int hx [6] = '{0, 1, 1, 1, 0, 0};
        do_rst();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 1, 1, 0, 0, 0, 0, 4, 0, 0);
                1: drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
                2: drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
                3: drive(1, 1, 4, 0, 0, 0, 0, 1, 0, 1);
                4: drive(1, 0, 0, 0, 3, 3, 1, 0, 0, 0);
                default: drive(1, 0, 0, 0, 3, 4, 2, 0, 0, 0);
            endcase
            expect_(0, 0, hx[i], 0);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_f();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL flush[%0d] got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturate();
        int n = 0;
        int dh;
        do_rst();
        for (int i = 0; i < 35; i++) begin
            if (i == 34) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                n  = 0;
                dh = 0;
            end else begin
                dh = (i >= 1 && ((i - 1) % 4) != 3) ? 1 : 0;
            end
            if (i == 0) drive(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
            else        drive(1, 1, 3, 1, 1, 3, 0, 0, 0, 0);
            expect_(dh, 0, 0, (n > 15) ? 15 : n);
            #2;
            e = sbq.pop_front();
            want = {e.dh, e.fwd, e.ch, e.cnt};
            got  = got_l();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL saturate[%0d] got %h want %h", i, got, want);
            end
            if (dh != 0) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_alu_fwd();
        test_multi_port();
        test_load_use();
        test_legacy();
        test_ctrl();
        test_flush();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/hazard_unit_fwd.md
HAZARD_UNIT_FWD -- requirements
Module: hazard_unit_fwd

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_W, default 5: register address width.
- NUM_RD, default 2: number of decode read ports.
- DEPTH, default 3: tracked stages (0=IDEX, 1=EXMEM, 2=MEMWB); legal range 2..4.
- FWD_EN, default 1: 1 enables forwarding; 0 makes every match a stall, as in the legacy unit.
- CNT_W, default 16: stall counter width.
REQ-002 Ports SHALL be as follows:
- clk, in, 1: one clock; all state updates on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- dec_valid, in, 1: decode holds a real instruction.
- dec_wr_en, in, 1: decode instruction writes a register.
- dec_wr_addr, in, ADDR_W: decode destination, already resolved ($SP for call/ret/push/pop, rt/rd per format).
- dec_is_load, in, 1: destination data becomes available only at MEMWB.
- rd_en, in, NUM_RD: per-port read enable.
- rd_addr, in, NUM_RD*ADDR_W: per-port read address, port p at bits [p*ADDR_W +: ADDR_W].
- ctrl_issue, in, 3: one-hot {branch, ret, call} issued from decode.
- ctrl_clr, in, 3: one-hot {branch, ret, call} resolved.
- flush, in, 1: pipeline flush.
- data_hazard, out, 1: stall decode this cycle.
- fwd_sel, out, NUM_RD*2: per-port source; 0=regfile, 1=IDEX, 2=EXMEM, 3=MEMWB.
- control_hazard, out, 1: redirect pending.
- stall_cnt, out, CNT_W: saturating count of stall cycles.

Function
REQ-003 The block SHALL keep a tag pipeline of DEPTH entries {valid, is_load, addr}, registered, shifting by one entry every cycle.
REQ-004 Entry 0 SHALL load {dec_valid & dec_wr_en, dec_is_load, dec_wr_addr} when data_hazard=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-005 A port p match at stage s SHALL be defined as rd_en[p] & entry[s].valid & (entry[s].addr == rd_addr[p]).
REQ-006 With FWD_EN=1, fwd_sel[p] SHALL select the youngest matching stage (lowest s); it SHALL be 0 when no stage matches.
REQ-007 With FWD_EN=1, data_hazard SHALL assert only when some port's youngest match is at stage 0 with is_load=1 (load-use), which gives exactly one stall cycle.
REQ-008 With FWD_EN=0, data_hazard SHALL assert on any match at any stage, and fwd_sel SHALL be all zero.
REQ-009 data_hazard and fwd_sel SHALL be combinational from the current inputs and registered state, with zero-cycle latency.
REQ-010 Three pending flags (call, ret, branch) SHALL each set on the cycle after their ctrl_issue bit, provided data_hazard=0, and clear on the cycle after their ctrl_clr bit.
REQ-011 When issue and clear of the same kind occur in the same cycle, issue SHALL win and the flag SHALL stay set.
REQ-012 control_hazard SHALL be the OR of the three pending flags.
REQ-013 flush SHALL invalidate all tag entries and clear all pending flags on the next edge, overriding dec inputs and ctrl_issue.
REQ-014 stall_cnt SHALL increment on every cycle with data_hazard=1 and SHALL saturate at all-ones with no wrap.
REQ-015 Multiple ports matching different stages SHALL be resolved independently per port.
REQ-016 A read of a register with no valid matching entry SHALL never stall.

Reset
REQ-017 On a rst edge, all tag entries SHALL become invalid, all pending flags SHALL clear, and stall_cnt SHALL become 0.
REQ-018 After reset, data_hazard=0, fwd_sel=0 and control_hazard=0 SHALL hold from the first cycle on.
REQ-019 rst SHALL override flush and all other inputs, including during a stall.

Structure
REQ-020 A shared package hazard_pkg SHALL hold the fwd_sel encodings (FWD_RF, FWD_IDEX, FWD_EXMEM, FWD_MEMWB), the ctrl bit indices and the tag-entry struct.
REQ-021 A single sub-module hazard_tag_pipe SHALL implement the DEPTH-entry tag shift register with bubble and flush inputs.
REQ-022 The match and priority logic SHALL be generated per port with a generate loop over NUM_RD.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ALU write r5, then next instruction reads r5 on port 0 -> data_hazard=0, fwd_sel[1:0]=1; one cycle later fwd_sel=2 if still read.
- Load to r7, then next instruction reads r7 on port 1 -> data_hazard=1 for exactly 1 cycle, stall_cnt=1, then fwd_sel[3:2]=2 with no stall.
- FWD_EN=0 build, write r3, then read r3 -> data_hazard high 3 consecutive cycles, stall_cnt=3.
- ctrl_issue=3'b001 at cycle N -> control_hazard=1 from N+1; ctrl_issue=ctrl_clr=3'b001 at N+3 -> still 1; ctrl_clr alone at N+5 -> 0 at N+6.
- Three valid entries plus a pending branch, then flush -> next cycle control_hazard=0 and a read of any prior destination gives fwd_sel=0.
- Force stall_cnt to all-ones, then hold a load-use stall -> stall_cnt stays all-ones; rst -> 0.
